reg8_seq_ctrl: RTL and testbench
================================

Name: reg8_seq_ctrl

Overview:
- Multi-cycle sequencer that drives the 8x8 register8_bank, which has two combinational read ports, one write port, x0 hardwired to zero, and a 2-cycle write-to-read latency.
- Fetches 16-bit instructions over a req/ack port, reads operands from the bank, executes 8-bit ALU, load-immediate and branch operations, and writes results back.
- Sits between the instruction memory and the bank. It is the only block that drives the bank ports.

Parameters:
- PC_W, 8, program counter width; wraps modulo 2^PC_W.
- WB_LAT, 2, bank write-to-read latency in cycles (write cycle included); minimum 1.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution at pc=0 from IDLE or HALTED
- instr_req  out  1  fetch request; held high until instr_ack
- instr_addr  out  PC_W  fetch address (= pc)
- instr_ack  in  1  instr_data valid this cycle
- instr_data  in  16  instruction word
- rb_write_enable  out  1  bank write enable
- rb_write_addr  out  3  bank write address
- rb_write_data  out  8  bank write data
- rb_reg_addr_1  out  3  bank read address 1
- rb_reg_addr_2  out  3  bank read address 2
- rb_reg_data_1  in  8  bank read data 1
- rb_reg_data_2  in  8  bank read data 2
- busy  out  1  high in any state except IDLE and HALTED
- halted  out  1  high in HALTED
- err_illegal  out  1  sticky flag: illegal opcode seen
- pc  out  PC_W  current program counter
- retired  out  CNT_W  count of completed instructions; saturates at all-ones

Behaviour:
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8/target.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2, modulo 2^8, carry/borrow discarded.
  - 6 LI: rd = imm8.
  - 7 HALT.
  - 8 JMP: pc = target.
  - 9 BZ: if R[rd]==0 then pc = target, else pc+1; R[rd] is read on port 1.
  - 10-15 illegal.
- Reset: state=IDLE, pc=0, instruction register=0, retired=0, err_illegal=0. All outputs are 0 the cycle after rst is sampled. rst overrides every other input, including mid-fetch and mid-writeback; a pending write is dropped.
- States IDLE, FETCH, EXEC, WB, WAIT, HALTED:
  - IDLE: start -> FETCH. Any other input is ignored.
  - FETCH: instr_req=1, instr_addr=pc. On instr_ack, latch instr_data into ir and go to EXEC. The earliest exit is 1 cycle.
  - EXEC (1 cycle):
    - rb_reg_addr_1/2 come from ir.
    - Result is computed from rb_reg_data_* and registered.
    - pc is updated: pc+1, or target for a taken JMP/BZ.
    - ALU/LI with rd!=0 -> WB.
    - ALU/LI with rd==0, NOP, JMP, BZ -> FETCH; retired increments.
    - HALT -> HALTED; pc is not advanced; retired increments.
    - Illegal -> set err_illegal, go to HALTED; retired does not increment.
  - WB (1 cycle): rb_write_enable=1, rb_write_addr=rd, rb_write_data=result; retired increments. Go to WAIT if WB_LAT>1, else FETCH.
  - WAIT: stays WB_LAT-1 cycles, then FETCH. This guarantees that a following instruction reading rd sees the new value.
  - HALTED: start -> clears halted, pc=0, FETCH. err_illegal and retired persist until rst.
- rb_write_enable is high only in WB. Read addresses hold their last value outside EXEC.
- start outside IDLE/HALTED is ignored.
- PC wrap: 2^PC_W-1 + 1 -> 0.
- Minimum cycles per instruction: 2 (no writeback) or 3+WB_LAT-1 (with writeback), assuming zero-wait ack.

Decomposition:
- Shared package reg8_seq_pkg holds:
  - opcode enum (opcode_e)
  - state enum (state_e)
  - field position constants
  - typedef instr_t (packed struct)
- One sub-module, reg8_seq_alu: combinational, opcode plus two 8-bit operands in, 8-bit result out.
- FSM, pc and counters stay in the top level.

Test Plan:
- rst, start, program {LI r1,0x05; LI r2,0x03; ADD r3,r1,r2; HALT}, ack same cycle -> exactly one write each: r1=0x05, r2=0x03, r3=0x08 (addr 3); halted=1, retired=4, pc=3.
- LI r1,0xFF; LI r2,0x01; ADD r3,r1,r2; SUB r4,r3,r2 -> r3=0x00, r4=0xFF (wrap both ways).
- LI r0,0x55; ADD r5,r0,r0 -> no write_enable for r0; r5 written 0x00.
- LI r1,0; BZ r1,0x10 at pc 1; HALT at 0x10 -> pc goes to 0x10, halted=1; same test with r1=1 falls through to pc 2.
- Opcode 0xC at pc 0 -> err_illegal=1, halted=1, retired=0, no write; start restarts at pc 0 with err_illegal still 1.
- rst asserted in WB cycle, and separately with instr_ack delayed 5 cycles -> next cycle rb_write_enable=0, instr_req=0, pc=0, state IDLE, retired=0.

Source files
------------

// File: rtl/reg8_seq_pkg.sv
// Shared types for the reg8 sequencer: opcodes, FSM states and the instruction layout.
package reg8_seq_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 3;
  localparam int IMM_W   = 8;
  localparam int PAD_W   = INSTR_W - OPC_W - 3 * REG_W;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LI   = 4'd6,
    OP_HALT = 4'd7,
    OP_JMP  = 4'd8,
    OP_BZ   = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // imm8/target overlaps the low bits of rs1 and all of rs2/pad.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [PAD_W-1:0] pad;
  } instr_t;

  function automatic logic [IMM_W-1:0] instr_imm(input instr_t i);
    return i[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/reg8_seq_ctrl_if.sv
// Fetch port and register-bank port of the reg8 sequencer, seen from the sequencer (master).
interface reg8_seq_ctrl_if
  import reg8_seq_pkg::*;
#(
  parameter int PC_W = 8
);
  logic               instr_req;
  logic [PC_W-1:0]    instr_addr;
  logic               instr_ack;
  logic [INSTR_W-1:0] instr_data;
  logic               rb_write_enable;
  logic [REG_W-1:0]   rb_write_addr;
  logic [7:0]         rb_write_data;
  logic [REG_W-1:0]   rb_reg_addr_1;
  logic [REG_W-1:0]   rb_reg_addr_2;
  logic [7:0]         rb_reg_data_1;
  logic [7:0]         rb_reg_data_2;

  modport master (
    output instr_req, instr_addr, rb_write_enable, rb_write_addr, rb_write_data,
           rb_reg_addr_1, rb_reg_addr_2,
    input  instr_ack, instr_data, rb_reg_data_1, rb_reg_data_2
  );

  modport slave (
    input  instr_req, instr_addr, rb_write_enable, rb_write_addr, rb_write_data,
           rb_reg_addr_1, rb_reg_addr_2,
    output instr_ack, instr_data, rb_reg_data_1, rb_reg_data_2
  );
endinterface

// File: rtl/reg8_seq_alu.sv
// Combinational 8-bit ALU for the reg8 sequencer; results wrap modulo 256.
module reg8_seq_alu
  import reg8_seq_pkg::*;
(
  input  logic [OPC_W-1:0] op,
  input  logic [7:0]       opnd_a,
  input  logic [7:0]       opnd_b,
  output logic [7:0]       result
);

  // Arithmetic/logic result select; carry and borrow out are dropped.
  always_comb begin
    result = 8'h00;
    case (op)
      OP_ADD:  result = opnd_a + opnd_b;
      OP_SUB:  result = opnd_a - opnd_b;
      OP_AND:  result = opnd_a & opnd_b;
      OP_OR:   result = opnd_a | opnd_b;
      OP_XOR:  result = opnd_a ^ opnd_b;
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/reg8_seq_ctrl.sv
// Multi-cycle sequencer: fetches 16-bit instructions, runs them against the 8x8 bank,
// and holds off the next fetch until a writeback is visible to reads.
module reg8_seq_ctrl
  import reg8_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  reg8_seq_ctrl_if.master   bus,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [PC_W-1:0]  PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       WAIT_LAST = 8'((WB_LAT > 1) ? (WB_LAT - 2) : 0);

  state_e            state_r, state_next_s;
  logic [PC_W-1:0]   pc_r, pc_next_s, pc_target_s;
  instr_t            ir_r, fetched_s;
  logic [7:0]        result_r, result_s, alu_y_s;
  logic [REG_W-1:0]  waddr_r, raddr1_s;
  logic [7:0]        wait_cnt_r;
  logic [CNT_W-1:0]  retired_r;
  logic              retire_s, set_err_s;
  logic              err_r, busy_r, halted_r, req_r, we_r;

  assign fetched_s   = instr_t'(bus.instr_data);
  assign pc_target_s = PC_W'(instr_imm(ir_r));

  reg8_seq_alu u_alu (
    .op     (ir_r.opcode),
    .opnd_a (bus.rb_reg_data_1),
    .opnd_b (bus.rb_reg_data_2),
    .result (alu_y_s)
  );

  // Writeback value: LI bypasses the ALU.
  always_comb begin
    if (ir_r.opcode == OP_LI) result_s = instr_imm(ir_r);
    else                      result_s = alu_y_s;
  end

  // BZ tests its rd register on read port 1.
  always_comb begin
    if (ir_r.opcode == OP_BZ) raddr1_s = ir_r.rd;
    else                      raddr1_s = ir_r.rs1;
  end

  // Next-state, next-pc and retire/error decode.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    retire_s     = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_next_s = ST_FETCH;
          pc_next_s    = {PC_W{1'b0}};
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FETCH: begin
        if (bus.instr_ack) state_next_s = ST_EXEC;
        else               state_next_s = ST_FETCH;
      end
      ST_EXEC: begin
        pc_next_s = pc_r + PC_ONE;
        case (ir_r.opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI: begin
            if (ir_r.rd != 3'd0) begin
              state_next_s = ST_WB;
            end else begin
              state_next_s = ST_FETCH;
              retire_s     = 1'b1;
            end
          end
          OP_NOP: begin
            state_next_s = ST_FETCH;
            retire_s     = 1'b1;
          end
          OP_JMP: begin
            pc_next_s    = pc_target_s;
            state_next_s = ST_FETCH;
            retire_s     = 1'b1;
          end
          OP_BZ: begin
            if (bus.rb_reg_data_1 == 8'h00) pc_next_s = pc_target_s;
            else                            pc_next_s = pc_r + PC_ONE;
            state_next_s = ST_FETCH;
            retire_s     = 1'b1;
          end
          OP_HALT: begin
            pc_next_s    = pc_r;
            state_next_s = ST_HALTED;
            retire_s     = 1'b1;
          end
          default: begin
            // Illegal opcode: pc stays on the offending word.
            pc_next_s    = pc_r;
            state_next_s = ST_HALTED;
            set_err_s    = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        retire_s = 1'b1;
        if (WB_LAT > 1) state_next_s = ST_WAIT;
        else            state_next_s = ST_FETCH;
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) state_next_s = ST_FETCH;
        else                         state_next_s = ST_WAIT;
      end
      default: begin
        state_next_s = ST_IDLE;
        pc_next_s    = {PC_W{1'b0}};
      end
    endcase
  end

  // State, pc, counters and the status/strobe outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= {PC_W{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      wait_cnt_r <= 8'h00;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      busy_r   <= (state_next_s != ST_IDLE) && (state_next_s != ST_HALTED);
      halted_r <= (state_next_s == ST_HALTED);
      req_r    <= (state_next_s == ST_FETCH);
      we_r     <= (state_next_s == ST_WB);
      if (set_err_s) err_r <= 1'b1;
      if (retire_s && (retired_r != CNT_MAX)) retired_r <= retired_r + CNT_ONE;
      if (state_r == ST_WB)        wait_cnt_r <= 8'h00;
      else if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + 8'h01;
    end
  end

  // Instruction register and writeback datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r     <= instr_t'(16'h0000);
      result_r <= 8'h00;
      waddr_r  <= 3'd0;
    end else begin
      if ((state_r == ST_FETCH) && bus.instr_ack) ir_r <= fetched_s;
      if (state_r == ST_EXEC) begin
        result_r <= result_s;
        waddr_r  <= ir_r.rd;
      end
    end
  end

  assign bus.instr_req       = req_r;
  assign bus.instr_addr      = pc_r;
  assign bus.rb_write_enable = we_r;
  assign bus.rb_write_addr   = waddr_r;
  assign bus.rb_write_data   = result_r;
  assign bus.rb_reg_addr_1   = raddr1_s;
  assign bus.rb_reg_addr_2   = ir_r.rs2;
  assign busy                = busy_r;
  assign halted              = halted_r;
  assign err_illegal         = err_r;
  assign pc                  = pc_r;
  assign retired             = retired_r;

endmodule

// File: tb/tb_reg8_seq_ctrl.sv
// Self-checking bench: directed and random programs run against an instruction-level model,
// with a behavioural register bank that honours the write-to-read latency.
module tb_reg8_seq_ctrl;
  import reg8_seq_pkg::*;

  localparam int PC_W   = 8;
  localparam int WB_LAT = 2;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, halted, err_illegal;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] retired;

  reg8_seq_ctrl_if #(.PC_W(PC_W)) bus ();

  reg8_seq_ctrl #(.PC_W(PC_W), .WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master),
    .busy(busy), .halted(halted), .err_illegal(err_illegal), .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instruction memory and bank models ----------------
  logic [15:0] imem [256];
  int          ack_delay = 0;

  initial begin : responder
    int req_cnt = 0;
    bus.instr_ack  = 1'b0;
    bus.instr_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.instr_req) begin
        if (req_cnt >= ack_delay) begin
          bus.instr_ack  = 1'b1;
          bus.instr_data = imem[bus.instr_addr];
        end else begin
          bus.instr_ack = 1'b0;
        end
        req_cnt++;
      end else begin
        bus.instr_ack = 1'b0;
        req_cnt = 0;
      end
    end
  end

  typedef struct { logic [2:0] a; logic [7:0] d; int due; } wr_t;
  logic [7:0]  bank [8];
  logic        bank_clr = 1'b0;
  wr_t         pend_q[$];
  logic [10:0] got_q[$];
  int          cyc = 0;

  // A write made in cycle t is readable from cycle t+WB_LAT on.
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
      pend_q.delete();
    end else begin
      if (bus.rb_write_enable) begin
        pend_q.push_back('{bus.rb_write_addr, bus.rb_write_data, cyc + WB_LAT});
        got_q.push_back({bus.rb_write_addr, bus.rb_write_data});
      end
      while (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
        if (pend_q[0].a != 3'd0) bank[pend_q[0].a] <= pend_q[0].d;
        void'(pend_q.pop_front());
      end
    end
    cyc <= cyc + 1;
  end

  assign bus.rb_reg_data_1 = (bus.rb_reg_addr_1 == 3'd0) ? 8'h00 : bank[bus.rb_reg_addr_1];
  assign bus.rb_reg_data_2 = (bus.rb_reg_addr_2 == 3'd0) ? 8'h00 : bank[bus.rb_reg_addr_2];

  // ---------------- instruction-level reference model ----------------
  logic [10:0] exp_q[$];
  int          exp_cycles, exp_retired;
  logic [7:0]  exp_pc;
  logic        exp_err;

  task automatic run_model(input int d);
    logic [7:0]  r [8];
    logic [7:0]  mpc, a, b, v, imm;
    logic [15:0] w;
    logic [3:0]  op;
    logic [2:0]  rd;
    bit          done;
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    exp_q.delete();
    mpc = 8'h00; exp_cycles = 0; exp_retired = 0; exp_err = 1'b0; done = 1'b0;
    for (int steps = 0; steps < 2000 && !done; steps++) begin
      w = imem[mpc]; op = w[15:12]; rd = w[11:9]; imm = w[7:0];
      a = r[w[8:6]]; b = r[w[5:3]];
      exp_cycles += 2 + d;
      if (op >= 4'd1 && op <= 4'd6) begin
        case (op)
          4'd1:    v = a + b;
          4'd2:    v = a - b;
          4'd3:    v = a & b;
          4'd4:    v = a | b;
          4'd5:    v = a ^ b;
          default: v = imm;
        endcase
        if (rd != 3'd0) begin
          r[rd] = v;
          exp_q.push_back({rd, v});
          exp_cycles += WB_LAT;
        end
        mpc++; exp_retired++;
      end else if (op == 4'd0) begin
        mpc++; exp_retired++;
      end else if (op == 4'd7) begin
        exp_retired++; done = 1'b1;
      end else if (op == 4'd8) begin
        mpc = imm; exp_retired++;
      end else if (op == 4'd9) begin
        if (r[rd] == 8'h00) mpc = imm;
        else                mpc++;
        exp_retired++;
      end else begin
        exp_err = 1'b1; done = 1'b1;
      end
    end
    exp_pc = mpc;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_imm(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  task automatic clr_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bank_clr = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check_value("rst/flags", {busy, halted, err_illegal, bus.instr_req, bus.rb_write_enable}, 32'd0);
    check_value("rst/pc", pc, 32'd0);
    check_value("rst/retired", retired, 32'd0);
    rst = 1'b0; bank_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_prog(input string name, input int d, output int base);
    int n;
    run_model(d);
    do_reset();
    ack_delay = d;
    base = got_q.size();
    pulse_start();
    n = 0;
    while (n < 4000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (halted) break;
    end
    check_value({name, "/halted"}, halted, 32'd1);
    check_value({name, "/cycles"}, n, exp_cycles);
    check_value({name, "/retired"}, retired, exp_retired);
    check_value({name, "/err"}, err_illegal, exp_err);
    if (!exp_err) check_value({name, "/pc"}, pc, exp_pc);
    check_value({name, "/nwrites"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      check_value({name, "/write"}, got_q[base + i], exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int base, n, len;
    logic [3:0] op;
    clr_imem();

    clr_imem();
    imem[0] = enc_imm(4'd6, 3'd1, 8'h05); imem[1] = enc_imm(4'd6, 3'd2, 8'h03);
    imem[2] = enc(4'd1, 3'd3, 3'd1, 3'd2); imem[3] = 16'h7000;
    run_prog("li_add", 0, base);
    check_value("li_add/r3", got_q[got_q.size() - 1], {3'd3, 8'h08});
    check_value("li_add/ret4", retired, 32'd4);
    check_value("li_add/pc3", pc, 32'd3);

    clr_imem();
    imem[0] = enc_imm(4'd6, 3'd1, 8'hFF); imem[1] = enc_imm(4'd6, 3'd2, 8'h01);
    imem[2] = enc(4'd1, 3'd3, 3'd1, 3'd2); imem[3] = enc(4'd2, 3'd4, 3'd3, 3'd2);
    run_prog("wrap", 1, base);
    check_value("wrap/r4", got_q[got_q.size() - 1], {3'd4, 8'hFF});

    clr_imem();
    imem[0] = enc_imm(4'd6, 3'd0, 8'h55); imem[1] = enc(4'd1, 3'd5, 3'd0, 3'd0);
    run_prog("x0", 2, base);
    check_value("x0/r5", got_q[got_q.size() - 1], {3'd5, 8'h00});

    for (int t = 0; t < 2; t++) begin
      clr_imem();
      imem[0] = enc_imm(4'd6, 3'd1, 8'(t)); imem[1] = enc_imm(4'd9, 3'd1, 8'h10);
      run_prog(t == 0 ? "bz_taken" : "bz_fall", 0, base);
      check_value("bz/pc", pc, (t == 0) ? 32'h10 : 32'h2);
    end

    clr_imem();
    imem[0] = 16'hC000;
    run_prog("illegal", 0, base);
    check_value("illegal/ret0", retired, 32'd0);
    pulse_start();
    check_value("restart/flags", {busy, halted, err_illegal}, 32'b101);
    check_value("restart/pc", pc, 32'd0);

    clr_imem();
    imem[0] = enc_imm(4'd9, 3'd2, 8'hFE); imem[8'hFE] = enc_imm(4'd6, 3'd2, 8'h01);
    imem[8'hFF] = 16'h0000; imem[1] = 16'h7000;
    run_prog("pc_wrap", 0, base);
    check_value("pc_wrap/pc", pc, 32'd1);

    // Reset landing on a writeback cycle.
    clr_imem();
    imem[0] = 16'h0000; imem[1] = enc_imm(4'd6, 3'd1, 8'h05);
    do_reset(); ack_delay = 0; pulse_start();
    n = 0;
    while (!bus.rb_write_enable && n < 50) begin @(negedge clk); n++; end
    check_value("rst_wb/in_wb", bus.rb_write_enable, 32'd1);
    rst = 1'b1; @(negedge clk);
    check_value("rst_wb/flags", {busy, bus.instr_req, bus.rb_write_enable}, 32'd0);
    check_value("rst_wb/pc_ret", {pc, retired}, 32'd0);
    rst = 1'b0;

    // Reset landing on a stalled fetch.
    do_reset(); ack_delay = 5; pulse_start();
    repeat (2) @(negedge clk);
    check_value("rst_fetch/req", {busy, bus.instr_req}, 32'b11);
    rst = 1'b1; @(negedge clk);
    check_value("rst_fetch/flags", {busy, bus.instr_req, bus.rb_write_enable}, 32'd0);
    check_value("rst_fetch/pc_ret", {pc, retired}, 32'd0);
    rst = 1'b0; ack_delay = 0;

    // Random forward-only programs ending in HALT.
    for (int p = 0; p < 20; p++) begin
      clr_imem();
      len = $urandom_range(6, 16);
      for (int a = 0; a < len - 1; a++) begin
        if ($urandom_range(0, 99) < 4) op = 4'($urandom_range(10, 15));
        else                            op = 4'($urandom_range(0, 9));
        if (op == 4'd7) op = 4'd6;
        if (op == 4'd8 || op == 4'd9)
          imem[a] = enc_imm(op, 3'($urandom_range(0, 7)), 8'($urandom_range(a + 1, len - 1)));
        else
          imem[a] = {op, 3'($urandom_range(0, 7)), 9'($urandom)};
      end
      run_prog("rand", $urandom_range(0, 3), base);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
